// File: rtl/read_port_arbiter.sv
// read_port_arbiter: N-master AXI read-channel arbiter in front of a single
// downstream read port. One burst is outstanding at a time. The R channel is a
// combinational pass-through steered by the latched grant.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no burst; pick a winner among m_arvalid and latch its AR fields
// ADDR   | ARVALID driven from latched fields; wait for ARREADY
// DATA   | forward R beats to the grantee until the RLAST handshake
module read_port_arbiter #(
  parameter int READ_MASTERS = 2,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int ARB_MODE     = 1,
  localparam int IDX_W = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [READ_MASTERS-1:0]             m_arvalid,
  output logic [READ_MASTERS-1:0]             m_arready,
  input  logic [READ_MASTERS*ID_WIDTH-1:0]    m_arid,
  input  logic [READ_MASTERS*4-1:0]           m_arlen,
  input  logic [READ_MASTERS*ADDR_WIDTH-1:0]  m_araddr,
  output logic [READ_MASTERS-1:0]             m_rvalid,
  input  logic [READ_MASTERS-1:0]             m_rready,
  output logic [READ_MASTERS-1:0]             m_rlast,
  output logic [READ_MASTERS*ID_WIDTH-1:0]    m_rid,
  output logic [READ_MASTERS*DATA_WIDTH-1:0]  m_rdata,
  output logic                                ARVALID,
  input  logic                                ARREADY,
  output logic [ID_WIDTH-1:0]                 ARID,
  output logic [3:0]                          ARLEN,
  output logic [ADDR_WIDTH-1:0]               ARADDR,
  input  logic                                RVALID,
  output logic                                RREADY,
  input  logic                                RLAST,
  input  logic [ID_WIDTH-1:0]                 RID,
  input  logic [DATA_WIDTH-1:0]               RDATA,
  output logic                                grant_valid,
  output logic [IDX_W-1:0]                    grant_idx,
  output logic                                protocol_error
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_grant_idx;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [ID_WIDTH-1:0]     r_id;
  logic [3:0]              r_len;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [3:0]              r_beat_cnt;
  logic                    r_err;
  logic                    r_arvalid;
  logic                    r_grant_valid;

  logic                    w_any_req;
  logic [IDX_W-1:0]        w_win_idx;
  logic [ID_WIDTH-1:0]     w_sel_id;
  logic [3:0]              w_sel_len;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [READ_MASTERS-1:0] w_is_grant;
  logic                    w_in_addr;
  logic                    w_in_data;
  logic                    w_rready;
  logic                    w_beat_hs;
  logic [IDX_W-1:0]        w_rr_next;

  // Winner search: scan offsets from high to low so the smallest offset wins.
  // Fixed priority scans from index 0, round robin from r_rr_ptr with wrap.
  always_comb begin
    int j;
    j         = 0;
    w_any_req = |m_arvalid;
    w_win_idx = '0;
    for (int k = READ_MASTERS - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        j = k;
      end else begin
        j = int'(r_rr_ptr) + k;
        if (j >= READ_MASTERS) j = j - READ_MASTERS;
      end
      if (m_arvalid[j]) w_win_idx = IDX_W'(j);
    end
  end

  // Select the winner's request fields and decode the current grant one-hot.
  always_comb begin
    w_sel_id   = '0;
    w_sel_len  = '0;
    w_sel_addr = '0;
    w_is_grant = '0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_sel_id   = m_arid[i*ID_WIDTH +: ID_WIDTH];
        w_sel_len  = m_arlen[i*4 +: 4];
        w_sel_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      w_is_grant[i] = (r_grant_idx == IDX_W'(i));
    end
  end

  assign w_in_addr = (r_state == S_ADDR);
  assign w_in_data = (r_state == S_DATA);
  assign w_rr_next = (int'(r_grant_idx) == READ_MASTERS - 1) ? '0
                                                             : r_grant_idx + IDX_W'(1);

  // Steer handshakes to the grantee only; data and ID are broadcast.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    m_rid     = '0;
    m_rdata   = '0;
    w_rready  = 1'b0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      m_arready[i] = w_is_grant[i] & w_in_addr & ARREADY;
      m_rvalid[i]  = w_is_grant[i] & w_in_data & RVALID;
      m_rlast[i]   = w_is_grant[i] & w_in_data & RLAST;
      m_rid[i*ID_WIDTH +: ID_WIDTH]       = RID;
      m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = RDATA;
      w_rready     = w_rready | (w_is_grant[i] & m_rready[i]);
    end
  end

  assign RREADY    = w_in_data & w_rready;
  assign w_beat_hs = RVALID & RREADY;

  // Arbitration FSM with beat counting and sticky burst-length check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_idx   <= '0;
      r_rr_ptr      <= '0;
      r_id          <= '0;
      r_len         <= '0;
      r_addr        <= '0;
      r_beat_cnt    <= '0;
      r_err         <= 1'b0;
      r_arvalid     <= 1'b0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_idx   <= w_win_idx;
            r_id          <= w_sel_id;
            r_len         <= w_sel_len;
            r_addr        <= w_sel_addr;
            r_arvalid     <= 1'b1;
            r_grant_valid <= 1'b1;
            r_state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ARREADY) begin
            r_beat_cnt <= '0;
            r_arvalid  <= 1'b0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat_hs) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (RLAST && (r_beat_cnt != r_len)) r_err <= 1'b1;
            if (!RLAST && (r_beat_cnt == r_len)) r_err <= 1'b1;
            if (RLAST) begin
              r_grant_valid <= 1'b0;
              r_state       <= S_IDLE;
              if (ARB_MODE == 1) r_rr_ptr <= w_rr_next;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_arvalid     <= 1'b0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ARVALID        = r_arvalid;
  assign ARID           = r_id;
  assign ARLEN          = r_len;
  assign ARADDR         = r_addr;
  assign grant_valid    = r_grant_valid;
  assign grant_idx      = r_grant_idx;
  assign protocol_error = r_err;

endmodule

// File: tb/tb_read_port_arbiter.sv
// Directed bench for read_port_arbiter: a round-robin and a fixed-priority
// instance (3 masters each) share one set of stimulus signals.
module tb_read_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  m_arvalid;
  logic [11:0] m_arid;
  logic [11:0] m_arlen;
  logic [77:0] m_araddr;
  logic [2:0]  m_rready;
  logic        ARREADY;
  logic        RVALID;
  logic        RLAST;
  logic [3:0]  RID;
  logic [31:0] RDATA;

  logic [2:0]  rr_m_arready, rr_m_rvalid, rr_m_rlast;
  logic [11:0] rr_m_rid;
  logic [95:0] rr_m_rdata;
  logic        rr_ARVALID, rr_RREADY, rr_grant_valid, rr_protocol_error;
  logic [3:0]  rr_ARID, rr_ARLEN;
  logic [25:0] rr_ARADDR;
  logic [1:0]  rr_grant_idx;

  logic [2:0]  fp_m_arready, fp_m_rvalid, fp_m_rlast;
  logic [11:0] fp_m_rid;
  logic [95:0] fp_m_rdata;
  logic        fp_ARVALID, fp_RREADY, fp_grant_valid, fp_protocol_error;
  logic [3:0]  fp_ARID, fp_ARLEN;
  logic [25:0] fp_ARADDR;
  logic [1:0]  fp_grant_idx;

  int n_tests = 0;
  int n_fail  = 0;

  read_port_arbiter #(.READ_MASTERS(3), .ADDR_WIDTH(26), .DATA_WIDTH(32),
                      .ID_WIDTH(4), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(rr_m_arready), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_araddr(m_araddr),
    .m_rvalid(rr_m_rvalid), .m_rready(m_rready), .m_rlast(rr_m_rlast),
    .m_rid(rr_m_rid), .m_rdata(rr_m_rdata),
    .ARVALID(rr_ARVALID), .ARREADY(ARREADY), .ARID(rr_ARID), .ARLEN(rr_ARLEN),
    .ARADDR(rr_ARADDR),
    .RVALID(RVALID), .RREADY(rr_RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .grant_valid(rr_grant_valid), .grant_idx(rr_grant_idx),
    .protocol_error(rr_protocol_error)
  );

  read_port_arbiter #(.READ_MASTERS(3), .ADDR_WIDTH(26), .DATA_WIDTH(32),
                      .ID_WIDTH(4), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(fp_m_arready), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_araddr(m_araddr),
    .m_rvalid(fp_m_rvalid), .m_rready(m_rready), .m_rlast(fp_m_rlast),
    .m_rid(fp_m_rid), .m_rdata(fp_m_rdata),
    .ARVALID(fp_ARVALID), .ARREADY(ARREADY), .ARID(fp_ARID), .ARLEN(fp_ARLEN),
    .ARADDR(fp_ARADDR),
    .RVALID(RVALID), .RREADY(fp_RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .grant_valid(fp_grant_valid), .grant_idx(fp_grant_idx),
    .protocol_error(fp_protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [3:0] id, input logic [3:0] len,
                         input logic [25:0] addr);
    m_arid[m*4 +: 4]    = id;
    m_arlen[m*4 +: 4]   = len;
    m_araddr[m*26 +: 26] = addr;
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    m_arvalid = '0;
    m_rready  = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RID       = '0;
    RDATA     = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Request from master m, accept the address at once; returns in the first DATA cycle.
  task automatic start_burst(input int m, input logic [3:0] id, input logic [3:0] len,
                             input logic [25:0] addr);
    set_req(m, id, len, addr);
    m_arvalid = 3'b001 << m;
    ARREADY   = 1'b1;
    m_rready  = 3'b111;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    tick();
    tick();
    m_arvalid = '0;
    ARREADY   = 1'b0;
  endtask

  initial begin
    int exp_rr [5];
    int exp_fp [4];
    exp_rr = '{0, 1, 2, 0, 1};
    exp_fp = '{0, 0, 0, 2};

    rst_n = 1'b0; m_arvalid = '0; m_arid = '0; m_arlen = '0; m_araddr = '0;
    m_rready = '0; ARREADY = 0; RVALID = 0; RLAST = 0; RID = '0; RDATA = '0;

    // Reset values
    do_reset();
    #1;
    chk("rst_arvalid", rr_ARVALID, 0);
    chk("rst_rready", rr_RREADY, 0);
    chk("rst_m_arready", rr_m_arready, 0);
    chk("rst_m_rvalid", rr_m_rvalid, 0);
    chk("rst_m_rlast", rr_m_rlast, 0);
    chk("rst_grant_valid", rr_grant_valid, 0);
    chk("rst_grant_idx", rr_grant_idx, 0);
    chk("rst_perr", rr_protocol_error, 0);

    // Single request: master 1, ARLEN=3, addr 0x100
    set_req(1, 4'd5, 4'd3, 26'h100);
    m_arvalid = 3'b010; ARREADY = 1'b1; m_rready = 3'b111;
    #1 chk("t1_idle_arvalid", rr_ARVALID, 0);
    tick(); #1;
    chk("t1_arvalid", rr_ARVALID, 1);
    chk("t1_araddr", rr_ARADDR, 26'h100);
    chk("t1_arlen", rr_ARLEN, 3);
    chk("t1_arid", rr_ARID, 5);
    chk("t1_m_arready", rr_m_arready, 3'b010);
    chk("t1_grant_idx", rr_grant_idx, 1);
    chk("t1_grant_valid", rr_grant_valid, 1);
    tick();
    m_arvalid = '0; ARREADY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      RVALID = 1'b1; RLAST = (b == 3); RID = 4'd5; RDATA = 32'hA0 + b;
      #1;
      chk("t1_m_rvalid", rr_m_rvalid, 3'b010);
      chk("t1_m_rlast", rr_m_rlast, (b == 3) ? 3'b010 : 3'b000);
      chk("t1_rready", rr_RREADY, 1);
      chk("t1_rdata", rr_m_rdata[63:32], 32'hA0 + b);
      chk("t1_rid", rr_m_rid[7:4], 5);
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("t1_end_grant_valid", rr_grant_valid, 0);
    chk("t1_end_perr", rr_protocol_error, 0);

    // Round robin with all three requesting, ARLEN=0
    do_reset();
    set_req(0, 4'd1, 4'd0, 26'h10);
    set_req(1, 4'd2, 4'd0, 26'h20);
    set_req(2, 4'd3, 4'd0, 26'h30);
    m_arvalid = 3'b111; ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; m_rready = 3'b111;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk("rr_idle_grant_valid", rr_grant_valid, 0);
      chk("rr_idle_arvalid", rr_ARVALID, 0);
      tick(); #1;
      chk("rr_grant_idx", rr_grant_idx, exp_rr[b]);
      chk("rr_arvalid", rr_ARVALID, 1);
      chk("rr_m_arready", rr_m_arready, 3'b001 << exp_rr[b]);
      chk("rr_araddr", rr_ARADDR, (exp_rr[b] + 1) * 16);
      chk("fp_all_grant_idx", fp_grant_idx, 0);
      tick(); #1;
      chk("rr_m_rvalid", rr_m_rvalid, 3'b001 << exp_rr[b]);
      tick();
    end

    // Fixed priority: masters 0 and 2; master 0 drops after its third burst
    do_reset();
    set_req(0, 4'd1, 4'd0, 26'h10);
    set_req(2, 4'd3, 4'd0, 26'h30);
    m_arvalid = 3'b101; ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; m_rready = 3'b111;
    for (int b = 0; b < 4; b++) begin
      #1 chk("fp_idle_grant_valid", fp_grant_valid, 0);
      tick(); #1;
      chk("fp_grant_idx", fp_grant_idx, exp_fp[b]);
      chk("fp_m_arready", fp_m_arready, 3'b001 << exp_fp[b]);
      tick();
      if (b == 2) m_arvalid = 3'b100;
      #1 chk("fp_m_rvalid", fp_m_rvalid, 3'b001 << exp_fp[b]);
      tick();
    end

    // Backpressure: ARREADY low 5 cycles, then m_rready low 3 cycles mid-burst
    do_reset();
    set_req(0, 4'd3, 4'd1, 26'h2A4);
    m_arvalid = 3'b001; ARREADY = 1'b0; m_rready = '0; RVALID = 1'b0; RLAST = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_arvalid", rr_ARVALID, 1);
      chk("bp_araddr", rr_ARADDR, 26'h2A4);
      chk("bp_arlen", rr_ARLEN, 1);
      chk("bp_arid", rr_ARID, 3);
      chk("bp_m_arready", rr_m_arready, 0);
      tick();
    end
    ARREADY = 1'b1;
    #1 chk("bp_m_arready_hs", rr_m_arready, 3'b001);
    tick();
    m_arvalid = '0; ARREADY = 1'b0; RVALID = 1'b1; m_rready = 3'b001; RLAST = 1'b0;
    #1 chk("bp_rready_beat0", rr_RREADY, 1);
    tick();
    m_rready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rready_stall", rr_RREADY, 0);
      chk("bp_m_rvalid_stall", rr_m_rvalid, 3'b001);
      tick();
    end
    m_rready = 3'b001; RLAST = 1'b1;
    #1;
    chk("bp_rready_last", rr_RREADY, 1);
    chk("bp_m_rlast", rr_m_rlast, 3'b001);
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("bp_perr", rr_protocol_error, 0);
    chk("bp_end_grant_valid", rr_grant_valid, 0);

    // Early RLAST: ARLEN=3, RLAST on third beat
    do_reset();
    start_burst(2, 4'd7, 4'd3, 26'h40);
    for (int b = 0; b < 3; b++) begin
      RVALID = 1'b1; RLAST = (b == 2); RDATA = b;
      #1 if (b == 2) chk("early_perr_before", rr_protocol_error, 0);
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("early_perr", rr_protocol_error, 1);
    chk("early_idle", rr_grant_valid, 0);
    tick(); #1;
    chk("early_perr_sticky", rr_protocol_error, 1);

    // Late RLAST: ARLEN=1, three beats
    do_reset();
    #1 chk("late_perr_cleared", rr_protocol_error, 0);
    start_burst(0, 4'd1, 4'd1, 26'h80);
    RVALID = 1'b1; RLAST = 1'b0;
    tick();
    tick();
    #1;
    chk("late_perr", rr_protocol_error, 1);
    chk("late_still_data", rr_grant_valid, 1);
    RLAST = 1'b1;
    #1 chk("late_m_rlast", rr_m_rlast, 3'b001);
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
    #1 chk("late_end_grant_valid", rr_grant_valid, 0);

    // Reset during beat 2 of an 8-beat burst
    do_reset();
    start_burst(2, 4'd9, 4'd7, 26'h200);
    RVALID = 1'b1; RLAST = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_arvalid", rr_ARVALID, 0);
    chk("mr_rready", rr_RREADY, 0);
    chk("mr_m_arready", rr_m_arready, 0);
    chk("mr_m_rvalid", rr_m_rvalid, 0);
    chk("mr_m_rlast", rr_m_rlast, 0);
    chk("mr_grant_valid", rr_grant_valid, 0);
    chk("mr_grant_idx", rr_grant_idx, 0);
    chk("mr_perr", rr_protocol_error, 0);
    tick();
    RVALID = 1'b0;
    set_req(1, 4'd4, 4'd0, 26'h300);
    m_arvalid = 3'b010; ARREADY = 1'b1;
    tick(); #1;
    chk("mr_new_grant_idx", rr_grant_idx, 1);
    chk("mr_new_arvalid", rr_ARVALID, 1);
    chk("mr_new_araddr", rr_ARADDR, 26'h300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_port_arbiter.md
# read_port_arbiter

Parametrised N-master AXI read-channel arbiter for the MIPS core memory subsystem. It sits between the cache read masters (i-cache, d-cache, and future prefetch or victim-buffer masters) and the single core-level AXI read port, and generalises the fixed two-master read arbitration to any master count. It supports selectable fixed-priority or round-robin grant, beat counting with burst-length checking, and one outstanding burst at a time.

## Interface
Parameters:
- READ_MASTERS, 2, number of upstream read masters (1..8)
- ADDR_WIDTH, 26, byte address width
- DATA_WIDTH, 32, read data width
- ID_WIDTH, 4, AXI ID width
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin

Ports. Per-master signals are packed vectors with master i in slice i.
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- m_arvalid  in  READ_MASTERS  master address request
- m_arready  out  READ_MASTERS  address accepted
- m_arid  in  READ_MASTERS*ID_WIDTH  master ID
- m_arlen  in  READ_MASTERS*4  burst length minus 1
- m_araddr  in  READ_MASTERS*ADDR_WIDTH  burst start address
- m_rvalid  out  READ_MASTERS  read beat valid
- m_rready  in  READ_MASTERS  master accepts beat
- m_rlast  out  READ_MASTERS  last beat
- m_rid  out  READ_MASTERS*ID_WIDTH  returned ID
- m_rdata  out  READ_MASTERS*DATA_WIDTH  beat data (broadcast to all masters)
- ARVALID/ARREADY/ARID/ARLEN/ARADDR  out/in/out/out/out  1/1/ID_WIDTH/4/ADDR_WIDTH  downstream address channel
- RVALID/RREADY/RLAST/RID/RDATA  in/out/in/in/in  1/1/1/ID_WIDTH/DATA_WIDTH  downstream data channel
- grant_valid  out  1  burst in progress (ADDR or DATA state)
- grant_idx  out  $clog2(READ_MASTERS) (minimum 1)  current grantee
- protocol_error  out  1  sticky; set on burst-length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, select a winner.
  - ARB_MODE=0: lowest set index wins.
  - ARB_MODE=1: first set index at or after rr_ptr, searching with wrap-around.
  - Latch grant_idx, ID, len and addr. Go to ADDR.
- ADDR:
  - ARVALID=1 with the latched fields.
  - m_arready[g] = ARREADY. All other m_arready bits are 0.
  - On ARVALID&&ARREADY: clear beat_cnt and go to DATA.
- DATA:
  - m_rvalid[g] = RVALID, m_rlast[g] = RLAST, m_rid[g] = RID. All other m_rvalid bits are 0.
  - RREADY = m_rready[g].
  - On each RVALID&&RREADY: beat_cnt increments (4-bit, wraps).
  - On the RLAST handshake: go to IDLE. In ARB_MODE=1, rr_ptr = g+1, wrapping to 0 after READ_MASTERS-1.
- Error check, evaluated on each accepted beat:
  - Set protocol_error if RLAST=1 with beat_cnt≠latched len.
  - Set protocol_error if RLAST=0 with beat_cnt==latched len.
  - Forwarding continues until RLAST regardless of errors.
- Masters must hold m_arvalid and the request fields stable until m_arready. Withdrawing a request before then gives undefined grant behaviour.
- The arbiter does not route on RID. Routing uses the latched grant, because only one burst is outstanding.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, protocol_error=0, grant_valid=0, grant_idx=0, beat_cnt=0.
  - ARVALID=0, RREADY=0, all m_arready=0, all m_rvalid=0, all m_rlast=0.
- Reset mid-burst drops the burst immediately with no drain. The downstream side must be reset on the same rst_n.
- Grant latency:
  - m_arvalid seen in IDLE at cycle 0 gives ARVALID=1 at cycle 1.
  - If ARREADY=1 at cycle 1, m_arready[g] pulses in cycle 1.
- Data path latency: R channel is combinational pass-through, zero added latency. Backpressure passes directly through m_rready to RREADY.
- After the RLAST handshake at cycle n, IDLE at n+1 and the next ARVALID at n+2. The minimum gap between bursts is 1 idle cycle.
- Simultaneous requests in one IDLE cycle: exactly one grant. Losers keep m_arready=0 and are re-evaluated in the next IDLE.
- READ_MASTERS=1: always grants master 0. The rr_ptr update is a no-op.
- ARLEN=15 gives 16 beats. beat_cnt reaches 15 on the last beat with no overflow error.

## Test plan
- Single request: master 1 sends ARLEN=3, addr 0x100, ARREADY tied high, RVALID every cycle → ARVALID at cycle +1, 4 beats routed only to master 1, RLAST on the 4th beat, protocol_error stays 0.
- Round robin: READ_MASTERS=3, ARB_MODE=1, all three request continuously with ARLEN=0 → grant order 0,1,2,0,1, with 1 idle cycle between bursts.
- Fixed priority: ARB_MODE=0, masters 0 and 2 request continuously → master 0 granted every time; master 2 is granted only after master 0 drops m_arvalid.
- Backpressure: ARLEN=1, ARREADY held low 5 cycles → ARVALID held and fields stable throughout. m_rready[g]=0 for 3 cycles during DATA → RREADY=0 and beat_cnt frozen.
- Length errors:
  - ARLEN=3, slave asserts RLAST on beat 2 → protocol_error=1 from the next cycle, FSM returns to IDLE.
  - ARLEN=1, slave sends 3 beats → protocol_error set on beat 2, burst ends at RLAST.
- Reset mid-burst: rst_n=0 during beat 2 of an 8-beat burst → next cycle all outputs are at reset values and state is IDLE. A new request after release is granted normally.
